// File: rtl/ascon_pack.sv
// Shared definitions for the ASCON data feeder.
//   type_feed_state : feeder FSM states
//   PAD_BYTE        : padding marker placed right after the last message byte
//   BLOCK_BYTES     : bytes per 64-bit rate block
package ascon_pack;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    FILL     = 3'd2,
    SEND     = 3'd3,
    WAIT_ACK = 3'd4,
    WAIT_END = 3'd5
  } type_feed_state;

  localparam logic [7:0] PAD_BYTE    = 8'h80;
  localparam int         BLOCK_BYTES = 8;

endpackage

// File: rtl/byte_packer.sv
// Packs host bytes big-endian into a 64-bit block and inserts padding.
// Ports:
//   clock_i, resetb_i : clock, asynchronous active-low reset
//   clear_i           : zero the word and the byte index
//   pad_blk_i         : load the stand-alone padding block 0x80_00..00
//   load_i            : write byte_i at the current index, advance the index
//   last_i            : byte being loaded ends the message (pad after it)
//   byte_i            : message byte
//   word_o            : packed block (registered)
//   idx_o             : index of the next byte slot
module byte_packer
  import ascon_pack::*;
(
  input  logic        clock_i,
  input  logic        resetb_i,
  input  logic        clear_i,
  input  logic        pad_blk_i,
  input  logic        load_i,
  input  logic        last_i,
  input  logic [7:0]  byte_i,
  output logic [63:0] word_o,
  output logic [2:0]  idx_o
);

  logic [63:0] word_q, word_d;
  logic [2:0]  idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (pad_blk_i) begin
      word_d = {PAD_BYTE, 56'h0};
      idx_d  = '0;
    end else if (load_i) begin
      // Byte k lands in bits [63-8k -: 8]. On the last byte, slot k+1 gets
      // the pad marker and every later slot is forced to zero.
      for (int j = 0; j < BLOCK_BYTES; j++) begin
        if (3'(j) == idx_q) begin
          word_d[63-8*j -: 8] = byte_i;
        end else if (last_i && (j > int'(idx_q))) begin
          word_d[63-8*j -: 8] = (j == int'(idx_q) + 1) ? PAD_BYTE : 8'h00;
        end
      end
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o = word_q;
  assign idx_o  = idx_q;

endmodule

// File: rtl/ascon_data_feeder.sv
// Feeds a byte stream from the host into an ASCON core as padded 64-bit
// blocks, handshaking each block with the core.
// Ports:
//   clock_i, resetb_i            : clock, asynchronous active-low reset
//   start_i                      : host begins a message (seen only in IDLE)
//   byte_i/byte_valid_i/byte_last_i, byte_ready_o : host byte stream
//   start_o                      : one-cycle start pulse to the core
//   data_o, data_valid_o         : packed block and its one-cycle strobe
//   ack_i                        : core consumed the current block
//   end_i                        : core finished (tag available)
//   busy_o                       : message in progress
module ascon_data_feeder
  import ascon_pack::*;
(
  input  logic        clock_i,
  input  logic        resetb_i,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_last_i,
  output logic        byte_ready_o,
  output logic        start_o,
  output logic [63:0] data_o,
  output logic        data_valid_o,
  input  logic        ack_i,
  input  logic        end_i,
  output logic        busy_o
);

  type_feed_state state_q, state_d;
  logic           final_q, final_d;
  logic           pad_pending_q, pad_pending_d;

  logic           pk_clear, pk_pad, pk_load;
  logic [2:0]     pk_idx;

  byte_packer u_packer (
    .clock_i   (clock_i),
    .resetb_i  (resetb_i),
    .clear_i   (pk_clear),
    .pad_blk_i (pk_pad),
    .load_i    (pk_load),
    .last_i    (byte_last_i),
    .byte_i    (byte_i),
    .word_o    (data_o),
    .idx_o     (pk_idx)
  );

  always_comb begin
    state_d       = state_q;
    final_d       = final_q;
    pad_pending_d = pad_pending_q;
    pk_clear      = 1'b0;
    pk_pad        = 1'b0;
    pk_load       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = START;
      end
      START: begin
        pk_clear      = 1'b1;
        final_d       = 1'b0;
        pad_pending_d = 1'b0;
        state_d       = FILL;
      end
      FILL: begin
        // byte_ready_o is 1 throughout FILL, so valid alone means transfer.
        if (byte_valid_i) begin
          pk_load = 1'b1;
          if (byte_last_i) begin
            // A full last block still needs a separate padding block.
            if (pk_idx == 3'd7) pad_pending_d = 1'b1;
            else                final_d       = 1'b1;
            state_d = SEND;
          end else if (pk_idx == 3'd7) begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // end_i here means the core gave up; abandon the message.
        if (end_i) begin
          state_d = IDLE;
        end else if (ack_i) begin
          if (pad_pending_q) begin
            pk_pad        = 1'b1;
            pad_pending_d = 1'b0;
            final_d       = 1'b1;
            state_d       = SEND;
          end else if (final_q) begin
            state_d = WAIT_END;
          end else begin
            pk_clear = 1'b1;
            state_d  = FILL;
          end
        end
      end
      WAIT_END: begin
        if (end_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q       <= IDLE;
      final_q       <= 1'b0;
      pad_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      final_q       <= final_d;
      pad_pending_q <= pad_pending_d;
    end
  end

  // Handshake outputs decode the state register only.
  assign byte_ready_o = (state_q == FILL);
  assign start_o      = (state_q == START);
  assign data_valid_o = (state_q == SEND);
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_ascon_data_feeder.sv
module tb_ascon_data_feeder;

  logic        clock_i = 1'b0;
  logic        resetb_i = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_last_i = 1'b0;
  logic        byte_ready_o;
  logic        start_o;
  logic [63:0] data_o;
  logic        data_valid_o;
  logic        ack_i = 1'b0;
  logic        end_i = 1'b0;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  ascon_data_feeder dut (
    .clock_i      (clock_i),
    .resetb_i     (resetb_i),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_last_i  (byte_last_i),
    .byte_ready_o (byte_ready_o),
    .start_o      (start_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .ack_i        (ack_i),
    .end_i        (end_i),
    .busy_o       (busy_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge right after the transfer.
  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    int n;
    for (int g = 0; g < gap; g++) @(negedge clock_i);
    byte_i       = b;
    byte_valid_i = 1'b1;
    byte_last_i  = last;
    n = 0;
    while (!byte_ready_o && n < 50) begin
      @(negedge clock_i);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 64'd0, 64'd1);
    @(negedge clock_i);
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    chk("start_pulse", 64'(start_o), 64'd1);
  endtask

  task automatic pulse_ack();
    ack_i = 1'b1;
    @(negedge clock_i);
    ack_i = 1'b0;
  endtask

  task automatic pulse_end();
    end_i = 1'b1;
    @(negedge clock_i);
    end_i = 1'b0;
  endtask

  // 11-byte message 00..0A, optional random gaps between bytes.
  task automatic msg11(input bit gaps);
    do_start();
    for (int i = 0; i < 8; i++)
      send_byte(8'(i), 1'b0, gaps ? int'($urandom_range(1, 5)) : 0);
    chk("m11_b1_valid", 64'(data_valid_o), 64'd1);
    chk("m11_b1_data", data_o, 64'h0001_0203_0405_0607);
    @(negedge clock_i);
    chk("m11_b1_pulse", 64'(data_valid_o), 64'd0);
    repeat (2) @(negedge clock_i);
    chk("m11_ready_wait_ack", 64'(byte_ready_o), 64'd0);
    pulse_ack();
    chk("m11_ready_after_ack", 64'(byte_ready_o), 64'd1);
    for (int i = 8; i < 11; i++)
      send_byte(8'(i), i == 10, gaps ? int'($urandom_range(1, 5)) : 0);
    chk("m11_b2_valid", 64'(data_valid_o), 64'd1);
    chk("m11_b2_data", data_o, 64'h0809_0A80_0000_0000);
    @(negedge clock_i);
    pulse_ack();
    chk("m11_wait_end_busy", 64'(busy_o), 64'd1);
    pulse_end();
    chk("m11_idle_busy", 64'(busy_o), 64'd0);
  endtask

  initial begin
    // Reset
    #12;
    chk("rst_start", 64'(start_o), 64'd0);
    chk("rst_valid", 64'(data_valid_o), 64'd0);
    chk("rst_ready", 64'(byte_ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_data", data_o, 64'd0);
    @(negedge clock_i);
    resetb_i = 1'b1;
    @(negedge clock_i);
    chk("idle_ready", 64'(byte_ready_o), 64'd0);

    // 3-byte message
    do_start();
    @(negedge clock_i);
    chk("fill_ready", 64'(byte_ready_o), 64'd1);
    chk("fill_busy", 64'(busy_o), 64'd1);
    send_byte(8'h01, 1'b0, 0);
    send_byte(8'h02, 1'b0, 0);
    send_byte(8'h03, 1'b1, 0);
    chk("m3_valid", 64'(data_valid_o), 64'd1);
    chk("m3_data", data_o, 64'h0102_0380_0000_0000);
    @(negedge clock_i);
    chk("m3_pulse", 64'(data_valid_o), 64'd0);
    chk("m3_hold", data_o, 64'h0102_0380_0000_0000);
    pulse_ack();
    chk("m3_wait_end_ready", 64'(byte_ready_o), 64'd0);
    pulse_end();
    chk("m3_idle_busy", 64'(busy_o), 64'd0);

    // 8-byte message: full block then pad block
    do_start();
    for (int i = 0; i < 8; i++) send_byte(8'(i), i == 7, 0);
    chk("m8_valid", 64'(data_valid_o), 64'd1);
    chk("m8_data", data_o, 64'h0001_0203_0405_0607);
    @(negedge clock_i);
    pulse_ack();
    chk("m8_pad_valid", 64'(data_valid_o), 64'd1);
    chk("m8_pad_data", data_o, 64'h8000_0000_0000_0000);
    @(negedge clock_i);
    pulse_ack();
    chk("m8_wait_end_busy", 64'(busy_o), 64'd1);
    chk("m8_wait_end_valid", 64'(data_valid_o), 64'd0);
    pulse_end();
    chk("m8_idle_busy", 64'(busy_o), 64'd0);

    // 11-byte message, back-to-back then with random gaps
    msg11(1'b0);
    msg11(1'b1);

    // Reset after 5 of 8 bytes
    do_start();
    for (int i = 0; i < 5; i++) send_byte(8'(i + 8'h10), 1'b0, 0);
    #2 resetb_i = 1'b0;
    #1;
    chk("arst_ready", 64'(byte_ready_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_data", data_o, 64'd0);
    chk("arst_start", 64'(start_o), 64'd0);
    chk("arst_valid", 64'(data_valid_o), 64'd0);
    @(negedge clock_i);
    resetb_i = 1'b1;
    byte_valid_i = 1'b1;
    repeat (3) @(negedge clock_i);
    chk("post_rst_ready", 64'(byte_ready_o), 64'd0);
    chk("post_rst_busy", 64'(busy_o), 64'd0);
    byte_valid_i = 1'b0;
    do_start();
    send_byte(8'hAA, 1'b0, 0);
    send_byte(8'hBB, 1'b1, 0);
    chk("m2_valid", 64'(data_valid_o), 64'd1);
    chk("m2_data", data_o, 64'hAABB_8000_0000_0000);
    @(negedge clock_i);
    pulse_ack();
    pulse_end();

    // end_i during WAIT_ACK aborts; start_i while busy is ignored
    do_start();
    send_byte(8'h55, 1'b1, 0);
    @(negedge clock_i);
    pulse_end();
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_ready", 64'(byte_ready_o), 64'd0);
    do_start();
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    chk("busy_start_ignored", 64'(start_o), 64'd0);
    @(negedge clock_i);
    chk("busy_start_no_pulse", 64'(start_o), 64'd0);
    send_byte(8'h11, 1'b1, 0);
    chk("m1_data", data_o, 64'h1180_0000_0000_0000);
    @(negedge clock_i);
    pulse_ack();
    pulse_end();
    chk("final_idle", 64'(busy_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ascon_data_feeder.md
ASCON_DATA_FEEDER -- requirements
Module: ascon_data_feeder

Interface
REQ-001 clock_i  in  1  single clock; all state updates on rising edge.
REQ-002 resetb_i  in  1  asynchronous active-low reset.
REQ-003 start_i  in  1  host request to begin one message; sampled only in IDLE.
REQ-004 byte_i  in  8  message byte from host.
REQ-005 byte_valid_i  in  1  byte_i valid; a byte transfers when byte_valid_i and byte_ready_o are both 1.
REQ-006 byte_last_i  in  1  qualifies the transferring byte as the final message byte.
REQ-007 byte_ready_o  out  1  feeder accepts a byte this cycle.
REQ-008 start_o  out  1  one-cycle pulse to the cipher core, which starts the permutation.
REQ-009 data_o  out  64  packed, padded block to the cipher core.
REQ-010 data_valid_o  out  1  one-cycle pulse; data_o is valid.
REQ-011 ack_i  in  1  core has consumed the current block (wired to the core's cipher_valid).
REQ-012 end_i  in  1  core finished and tag is available.
REQ-013 busy_o  out  1  high from accepted start_i until end_i is seen.

Function
REQ-014 The FSM SHALL have states IDLE, START, FILL, SEND, WAIT_ACK and WAIT_END.
REQ-015 IDLE: when start_i=1 -> START; otherwise stay in IDLE; byte_ready_o=0.
REQ-016 START: start_o=1 for exactly one cycle; clear the byte index and word register; -> FILL.
REQ-017 FILL: byte_ready_o=1; each transferred byte SHALL be written big-endian, with byte index k in data bits [63-8k -: 8], and the index SHALL increment.
REQ-018 FILL: a transfer at index 7 without last SHALL go to SEND with full=1 and pad_pending=0.
REQ-019 FILL: a transfer with last at index k<7 SHALL write 0x80 into byte k+1, zero bytes k+2..7, set final=1 and go to SEND.
REQ-020 FILL: a transfer with last at index 7 SHALL go to SEND and set pad_pending=1, so that an extra block 0x8000_0000_0000_0000 follows.
REQ-021 FILL with last=1 SHALL be handled as message end; an empty message (start_i then no bytes) is not supported, and the host SHALL send at least one byte.
REQ-022 SEND: data_valid_o=1 for one cycle with data_o stable; -> WAIT_ACK.
REQ-023 data_o SHALL hold its value from SEND until the next block is loaded.
REQ-024 WAIT_ACK: byte_ready_o=0. On ack_i: if pad_pending, load the pad block, clear pad_pending and set final, then -> SEND. Else if final, -> WAIT_END. Else clear the index and word, then -> FILL.
REQ-025 WAIT_END: on end_i -> IDLE and busy_o=0 in the following cycle.
REQ-026 ack_i or end_i outside WAIT_ACK or WAIT_END SHALL be ignored; start_i outside IDLE SHALL be ignored.
REQ-027 end_i arriving in WAIT_ACK SHALL abort to IDLE (core error recovery).
REQ-028 byte_ready_o SHALL be combinational from the state only, never from byte_valid_i.
REQ-029 Latency: from the last byte of a block to data_valid_o SHALL be 1 cycle; from ack_i to the pad-block data_valid_o SHALL be 1 cycle.

Reset
REQ-030 resetb_i=0 SHALL asynchronously force IDLE and set index=0, data_o=0, final=0 and pad_pending=0.
REQ-031 During reset, start_o, data_valid_o, byte_ready_o and busy_o SHALL all be 0.
REQ-032 Reset asserted mid-message SHALL discard the partial block; after release the block SHALL wait for a new start_i.

Structure
REQ-033 ascon_pack SHALL hold the state enum type_feed_state, the constant PAD_BYTE=8'h80 and the constant BLOCK_BYTES=8.
REQ-034 There SHALL be one sub-module, byte_packer, which holds the 64-bit word register, the 3-bit index and the pad insertion, with load, clear and pad controls.
REQ-035 All outputs SHALL be driven either from registers or from the state decode only.

Verification
REQ-036 Message of 3 bytes 01 02 03 -> start_o pulse, then data_o=0x0102_0380_0000_0000 and one data_valid_o.
REQ-037 Message of 8 bytes 00..07 -> block 0x0001_0203_0405_0607, then after ack_i the block 0x8000_0000_0000_0000, then WAIT_END.
REQ-038 Message of 11 bytes -> two blocks, the second being 0x0809_0A80_0000_0000; byte_ready_o=0 between the blocks until ack_i.
REQ-039 byte_valid_i toggled randomly with 1-5 idle cycles -> packed words identical to the back-to-back case.
REQ-040 resetb_i pulsed low after 5 of 8 bytes -> all outputs 0 immediately; a new 2-byte message afterwards yields 0xAABB_8000_0000_0000.
REQ-041 end_i in WAIT_ACK -> IDLE next cycle with busy_o=0; start_i while busy -> no second start_o.
